// File: rtl/rom_sched.sv
// rom_sched -- shared cartridge ROM port scheduler.
//
// Arbitrates one external ROM port between PRG fetches (CPU side) and CHR
// fetches (PPU side). Each 21-bit bank-resolved offset is translated to a
// 22-bit image address past the iNES header. CHR has fixed priority; a PRG
// skip counter forces a PRG grant after MAXSKIP consecutive losses.
//
// Optional feature macro: ROMSCHED_PREFETCH_EN
//   When defined, a one-entry sequential PRG prefetch buffer is built.
//
// Parameters:
//   HDR_BYTES  image bytes preceding PRG data
//   MAXSKIP    consecutive PRG losses before PRG is forced to win (1..15)
//
// Ports:
//   clk, rstn             clock, asynchronous active-low reset
//   prgsize               PRG ROM size in bytes (CHR base = HDR_BYTES + prgsize)
//   flush                 invalidate the prefetch buffer
//   promreq/promaddr      PRG request (level) and offset
//   promdata/promack      PRG data and one-cycle acknowledge
//   cromreq/cromaddr      CHR request (level) and offset
//   cromdata/cromack      CHR data and one-cycle acknowledge
//   romaddr/romreq        external ROM address and request
//   romdata/romack        external ROM data and one-cycle acknowledge
module rom_sched #(
   parameter int HDR_BYTES = 16,
   parameter int MAXSKIP   = 3
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [21:0] prgsize,
   input  logic        flush,
   input  logic        promreq,
   input  logic [20:0] promaddr,
   output logic [7:0]  promdata,
   output logic        promack,
   input  logic        cromreq,
   input  logic [20:0] cromaddr,
   output logic [7:0]  cromdata,
   output logic        cromack,
   output logic [21:0] romaddr,
   output logic        romreq,
   input  logic [7:0]  romdata,
   input  logic        romack
);

   localparam logic [21:0] HDR_C     = 22'(HDR_BYTES);
   localparam logic [3:0]  MAXSKIP_C = 4'(MAXSKIP);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PRG_WAIT = 2'd1,
      ST_CHR_WAIT = 2'd2,
      ST_PF_WAIT  = 2'd3
   } state_t;

   state_t      state_r, state_nxt_s;
   logic [3:0]  skip_r, skip_nxt_s;
   logic [21:0] romaddr_r, romaddr_nxt_s;
   logic        romreq_r, romreq_nxt_s;
   logic        promack_r, promack_nxt_s;
   logic        cromack_r, cromack_nxt_s;
   logic [7:0]  promdata_r, promdata_nxt_s;
   logic [7:0]  cromdata_r, cromdata_nxt_s;

   logic        prg_pend_s, chr_pend_s, hold_s, grant_prg_s;
   logic [21:0] prg_addr_s, chr_addr_s;

`ifdef ROMSCHED_PREFETCH_EN
   logic [20:0] pf_addr_r, pf_addr_nxt_s;
   logic [7:0]  pf_data_r, pf_data_nxt_s;
   logic        pf_valid_r, pf_valid_nxt_s;
   logic        pf_arm_r, pf_arm_nxt_s;
   logic [20:0] pf_next_r, pf_next_nxt_s;
   logic        pf_kill_r, pf_kill_nxt_s;
   logic [21:0] prgsize_r;
   logic        prgchg_s, pf_clear_s, pf_hit_s, pf_serve_s, pf_drop_s;
`else
   logic        flush_unused_s;
   assign flush_unused_s = flush;
`endif

   // A requester whose ack is on the outputs this cycle still holds req high;
   // that level belongs to the finished transfer, so it is masked. No grant
   // is made in an ack cycle so that both requesters re-arbitrate together.
   assign prg_pend_s  = promreq & ~promack_r;
   assign chr_pend_s  = cromreq & ~cromack_r;
   assign hold_s      = promack_r | cromack_r;
   assign grant_prg_s = prg_pend_s & (~chr_pend_s | (skip_r == MAXSKIP_C));
   assign prg_addr_s  = HDR_C + {1'b0, promaddr};
   assign chr_addr_s  = HDR_C + prgsize + {1'b0, cromaddr};

`ifdef ROMSCHED_PREFETCH_EN
   assign prgchg_s   = (prgsize != prgsize_r);
   assign pf_clear_s = flush | prgchg_s;
   assign pf_hit_s   = prg_pend_s & pf_valid_r & (promaddr == pf_addr_r);
   assign pf_serve_s = prg_pend_s & (promaddr == pf_addr_r) & ~pf_kill_r & ~pf_clear_s;
   assign pf_drop_s  = pf_kill_r | pf_clear_s | (prg_pend_s & (promaddr != pf_addr_r));
`endif

   // Next-state, grant and output computation.
   always_comb begin
      state_nxt_s    = state_r;
      skip_nxt_s     = skip_r;
      romaddr_nxt_s  = romaddr_r;
      romreq_nxt_s   = romreq_r;
      promack_nxt_s  = 1'b0;
      cromack_nxt_s  = 1'b0;
      promdata_nxt_s = promdata_r;
      cromdata_nxt_s = cromdata_r;
`ifdef ROMSCHED_PREFETCH_EN
      pf_addr_nxt_s  = pf_addr_r;
      pf_data_nxt_s  = pf_data_r;
      pf_valid_nxt_s = pf_valid_r;
      pf_arm_nxt_s   = pf_arm_r;
      pf_next_nxt_s  = pf_next_r;
      pf_kill_nxt_s  = pf_kill_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (hold_s) begin
               state_nxt_s = ST_IDLE;
            end
`ifdef ROMSCHED_PREFETCH_EN
            else if (pf_hit_s) begin
               // Buffer hit: answer without the ROM; a waiting CHR may still launch.
               promack_nxt_s  = 1'b1;
               promdata_nxt_s = pf_data_r;
               skip_nxt_s     = 4'd0;
               if (chr_pend_s) begin
                  romreq_nxt_s  = 1'b1;
                  romaddr_nxt_s = chr_addr_s;
                  state_nxt_s   = ST_CHR_WAIT;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
`endif
            else if (grant_prg_s) begin
               romreq_nxt_s  = 1'b1;
               romaddr_nxt_s = prg_addr_s;
               skip_nxt_s    = 4'd0;
               state_nxt_s   = ST_PRG_WAIT;
            end else if (chr_pend_s) begin
               romreq_nxt_s  = 1'b1;
               romaddr_nxt_s = chr_addr_s;
               state_nxt_s   = ST_CHR_WAIT;
               if (prg_pend_s && (skip_r != MAXSKIP_C)) begin
                  skip_nxt_s = skip_r + 4'd1;
               end else begin
                  skip_nxt_s = skip_r;
               end
            end
`ifdef ROMSCHED_PREFETCH_EN
            else if (pf_arm_r) begin
               romreq_nxt_s   = 1'b1;
               romaddr_nxt_s  = HDR_C + {1'b0, pf_next_r};
               pf_addr_nxt_s  = pf_next_r;
               pf_valid_nxt_s = 1'b0;
               pf_arm_nxt_s   = 1'b0;
               pf_kill_nxt_s  = 1'b0;
               state_nxt_s    = ST_PF_WAIT;
            end
`endif
            else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_PRG_WAIT: begin
            if (romack) begin
               romreq_nxt_s   = 1'b0;
               promack_nxt_s  = 1'b1;
               promdata_nxt_s = romdata;
               state_nxt_s    = ST_IDLE;
`ifdef ROMSCHED_PREFETCH_EN
               pf_next_nxt_s  = promaddr + 21'd1;
               pf_arm_nxt_s   = 1'b1;
`endif
            end else begin
               state_nxt_s = ST_PRG_WAIT;
            end
         end
         ST_CHR_WAIT: begin
            if (romack) begin
               romreq_nxt_s   = 1'b0;
               cromack_nxt_s  = 1'b1;
               cromdata_nxt_s = romdata;
               state_nxt_s    = ST_IDLE;
            end else begin
               state_nxt_s = ST_CHR_WAIT;
            end
         end
`ifdef ROMSCHED_PREFETCH_EN
         ST_PF_WAIT: begin
            if (romack) begin
               romreq_nxt_s = 1'b0;
               state_nxt_s  = ST_IDLE;
               if (pf_serve_s) begin
                  // A PRG request for the byte in flight is answered straight from romdata.
                  promack_nxt_s  = 1'b1;
                  promdata_nxt_s = romdata;
                  skip_nxt_s     = 4'd0;
                  pf_next_nxt_s  = pf_addr_r + 21'd1;
                  pf_arm_nxt_s   = 1'b1;
               end else begin
                  pf_arm_nxt_s = pf_arm_r;
               end
               if (pf_drop_s) begin
                  pf_valid_nxt_s = 1'b0;
               end else begin
                  pf_valid_nxt_s = 1'b1;
                  pf_data_nxt_s  = romdata;
               end
            end else begin
               state_nxt_s   = ST_PF_WAIT;
               pf_kill_nxt_s = pf_kill_r | pf_clear_s;
            end
         end
`endif
         default: begin
            state_nxt_s  = ST_IDLE;
            romreq_nxt_s = 1'b0;
         end
      endcase
`ifdef ROMSCHED_PREFETCH_EN
      pf_valid_nxt_s = pf_valid_nxt_s & ~pf_clear_s;
`endif
   end

   // State and registered-output update.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r    <= ST_IDLE;
         skip_r     <= 4'd0;
         romaddr_r  <= 22'd0;
         romreq_r   <= 1'b0;
         promack_r  <= 1'b0;
         cromack_r  <= 1'b0;
         promdata_r <= 8'd0;
         cromdata_r <= 8'd0;
      end else begin
         state_r    <= state_nxt_s;
         skip_r     <= skip_nxt_s;
         romaddr_r  <= romaddr_nxt_s;
         romreq_r   <= romreq_nxt_s;
         promack_r  <= promack_nxt_s;
         cromack_r  <= cromack_nxt_s;
         promdata_r <= promdata_nxt_s;
         cromdata_r <= cromdata_nxt_s;
      end
   end

`ifdef ROMSCHED_PREFETCH_EN
   // Prefetch buffer and prgsize tracking registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pf_addr_r  <= 21'd0;
         pf_data_r  <= 8'd0;
         pf_valid_r <= 1'b0;
         pf_arm_r   <= 1'b0;
         pf_next_r  <= 21'd0;
         pf_kill_r  <= 1'b0;
         prgsize_r  <= 22'd0;
      end else begin
         pf_addr_r  <= pf_addr_nxt_s;
         pf_data_r  <= pf_data_nxt_s;
         pf_valid_r <= pf_valid_nxt_s;
         pf_arm_r   <= pf_arm_nxt_s;
         pf_next_r  <= pf_next_nxt_s;
         pf_kill_r  <= pf_kill_nxt_s;
         prgsize_r  <= prgsize;
      end
   end
`endif

   assign romaddr  = romaddr_r;
   assign romreq   = romreq_r;
   assign promack  = promack_r;
   assign cromack  = cromack_r;
   assign promdata = promdata_r;
   assign cromdata = cromdata_r;

endmodule

// File: tb/tb_rom_sched.sv
// tb_rom_sched -- directed self-checking bench for rom_sched.
// A one-cycle ROM responder answers every romreq; each test task drives one
// scenario and compares observed outputs against hand-computed values.
module tb_rom_sched;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [21:0] prgsize = 22'h008000;
   logic        flush = 1'b0;
   logic        promreq = 1'b0;
   logic [20:0] promaddr = 21'd0;
   logic [7:0]  promdata;
   logic        promack;
   logic        cromreq = 1'b0;
   logic [20:0] cromaddr = 21'd0;
   logic [7:0]  cromdata;
   logic        cromack;
   logic [21:0] romaddr;
   logic        romreq;
   logic [7:0]  romdata;
   logic        romack;

   int errors = 0;
   int checks = 0;

   // Monitor state
   int   prom_ack_cnt = 0;
   int   crom_ack_cnt = 0;
   int   rom_req_cnt  = 0;
   logic both_ack_seen = 1'b0;
   logic addr_unstable = 1'b0;
   logic romreq_q = 1'b0;
   logic [21:0] req_addr_q = 22'd0;

   rom_sched #(.HDR_BYTES(16), .MAXSKIP(3)) dut (
      .clk(clk), .rstn(rstn), .prgsize(prgsize), .flush(flush),
      .promreq(promreq), .promaddr(promaddr), .promdata(promdata), .promack(promack),
      .cromreq(cromreq), .cromaddr(cromaddr), .cromdata(cromdata), .cromack(cromack),
      .romaddr(romaddr), .romreq(romreq), .romdata(romdata), .romack(romack)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rom_byte(input logic [21:0] a);
      return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'hA5;
   endfunction

   // One-cycle ROM responder
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         romack  <= 1'b0;
         romdata <= 8'd0;
      end else if (romreq && !romack) begin
         romack  <= 1'b1;
         romdata <= rom_byte(romaddr);
      end else begin
         romack  <= 1'b0;
      end
   end

   // Protocol monitor
   always @(negedge clk) begin
      if (promack) prom_ack_cnt <= prom_ack_cnt + 1;
      if (cromack) crom_ack_cnt <= crom_ack_cnt + 1;
      if (promack && cromack) both_ack_seen <= 1'b1;
      if (romreq && !romreq_q) begin
         rom_req_cnt <= rom_req_cnt + 1;
         req_addr_q  <= romaddr;
      end
      if (romreq && romreq_q && (romaddr != req_addr_q)) addr_unstable <= 1'b1;
      romreq_q <= romreq;
   end

   // Waits for the selected ack; reports latency (-1 on timeout), data and first romaddr.
   task automatic wait_ack(input bit is_chr, output int lat, output logic [7:0] data,
                           output logic [21:0] addr_seen, output bit req_seen);
      lat = -1; data = 8'd0; addr_seen = 22'd0; req_seen = 1'b0;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         if (!req_seen && romreq) begin
            req_seen  = 1'b1;
            addr_seen = romaddr;
         end
         if (is_chr ? cromack : promack) begin
            lat  = i;
            data = is_chr ? cromdata : promdata;
            break;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      idle(2);
      checks++; if (romreq !== 1'b0)      begin errors++; $display("FAIL reset_romreq got=%b exp=0", romreq); end
      checks++; if (romaddr !== 22'd0)    begin errors++; $display("FAIL reset_romaddr got=%h exp=0", romaddr); end
      checks++; if (promack !== 1'b0)     begin errors++; $display("FAIL reset_promack got=%b exp=0", promack); end
      checks++; if (cromack !== 1'b0)     begin errors++; $display("FAIL reset_cromack got=%b exp=0", cromack); end
      checks++; if (promdata !== 8'd0)    begin errors++; $display("FAIL reset_promdata got=%h exp=0", promdata); end
      checks++; if (cromdata !== 8'd0)    begin errors++; $display("FAIL reset_cromdata got=%h exp=0", cromdata); end
      rstn = 1'b1;
      idle(2);
   endtask

   task automatic test_prg_basic;
      int lat; logic [7:0] d; logic [21:0] a; bit rs; int c0;
      #1 c0 = prom_ack_cnt;
      promaddr = 21'h00010; promreq = 1'b1;
      wait_ack(1'b0, lat, d, a, rs);
      promreq = 1'b0;
      checks++; if (lat !== 3)                   begin errors++; $display("FAIL prg_latency got=%0d exp=3", lat); end
      checks++; if (a !== 22'h000020)            begin errors++; $display("FAIL prg_romaddr got=%h exp=000020", a); end
      checks++; if (d !== rom_byte(22'h000020))  begin errors++; $display("FAIL prg_data got=%h exp=%h", d, rom_byte(22'h000020)); end
      idle(1);
      checks++; if (promack !== 1'b0)            begin errors++; $display("FAIL prg_ack_width got=%b exp=0", promack); end
      idle(6);
      #1;
      checks++; if (prom_ack_cnt - c0 !== 1)     begin errors++; $display("FAIL prg_ack_count got=%0d exp=1", prom_ack_cnt - c0); end
   endtask

   task automatic test_chr_basic;
      int lat; logic [7:0] d; logic [21:0] a; bit rs; int c0;
      #1 c0 = crom_ack_cnt;
      prgsize = 22'h008000; cromaddr = 21'h00005; cromreq = 1'b1;
      wait_ack(1'b1, lat, d, a, rs);
      cromreq = 1'b0;
      checks++; if (lat !== 3)                   begin errors++; $display("FAIL chr_latency got=%0d exp=3", lat); end
      checks++; if (a !== 22'h008015)            begin errors++; $display("FAIL chr_romaddr got=%h exp=008015", a); end
      checks++; if (d !== rom_byte(22'h008015))  begin errors++; $display("FAIL chr_data got=%h exp=%h", d, rom_byte(22'h008015)); end
      idle(6);
      #1;
      checks++; if (crom_ack_cnt - c0 !== 1)     begin errors++; $display("FAIL chr_ack_count got=%0d exp=1", crom_ack_cnt - c0); end
   endtask

   task automatic test_wrap;
      int lat; logic [7:0] d; logic [21:0] a; bit rs;
      prgsize = 22'h3FFFF0; cromaddr = 21'h00020; cromreq = 1'b1;
      wait_ack(1'b1, lat, d, a, rs);
      cromreq = 1'b0;
      checks++; if (a !== 22'h000020)            begin errors++; $display("FAIL wrap_romaddr got=%h exp=000020", a); end
      checks++; if (d !== rom_byte(22'h000020))  begin errors++; $display("FAIL wrap_data got=%h exp=%h", d, rom_byte(22'h000020)); end
      prgsize = 22'h008000;
      idle(6);
   endtask

   task automatic test_contention;
      string got;
      string exp_s;
      exp_s = "CCCPCCCP";
      got = "";
      promaddr = 21'h00060; cromaddr = 21'h00007;
      promreq = 1'b1; cromreq = 1'b1;
      for (int i = 0; i < 200 && got.len() < 8; i++) begin
         @(negedge clk);
         if (cromack) got = {got, "C"};
         if (promack) got = {got, "P"};
      end
      promreq = 1'b0; cromreq = 1'b0;
      checks++; if (got != exp_s)       begin errors++; $display("FAIL contention_order got=%s exp=%s", got, exp_s); end
      idle(6);
      checks++; if (both_ack_seen !== 1'b0) begin errors++; $display("FAIL dual_ack got=%b exp=0", both_ack_seen); end
   endtask

   task automatic test_back_to_back;
      int lat; logic [7:0] d; logic [21:0] a; bit rs;
      promaddr = 21'h00030; promreq = 1'b1;
      wait_ack(1'b0, lat, d, a, rs);
      promaddr = 21'h00031;
      checks++; if (d !== rom_byte(22'h000040))  begin errors++; $display("FAIL b2b_first_data got=%h exp=%h", d, rom_byte(22'h000040)); end
      wait_ack(1'b0, lat, d, a, rs);
      promreq = 1'b0;
      checks++; if (lat < 1)                     begin errors++; $display("FAIL b2b_timeout got=%0d exp=>0", lat); end
      checks++; if (a !== 22'h000041)            begin errors++; $display("FAIL b2b_romaddr got=%h exp=000041", a); end
      checks++; if (d !== rom_byte(22'h000041))  begin errors++; $display("FAIL b2b_second_data got=%h exp=%h", d, rom_byte(22'h000041)); end
      idle(6);
   endtask

   task automatic test_reset_mid;
      int lat; logic [7:0] d; logic [21:0] a; bit rs; int c0;
      promaddr = 21'h00040; promreq = 1'b1;
      idle(1);
      checks++; if (romreq !== 1'b1)    begin errors++; $display("FAIL midrst_romreq_before got=%b exp=1", romreq); end
      rstn = 1'b0;
      #1;
      checks++; if (romreq !== 1'b0 || romaddr !== 22'd0 || promack !== 1'b0 || cromack !== 1'b0 ||
                    promdata !== 8'd0 || cromdata !== 8'd0) begin
         errors++; $display("FAIL midrst_outputs got=%b/%h/%b/%b/%h/%h exp=all zero",
                             romreq, romaddr, promack, cromack, promdata, cromdata);
      end
      idle(2);
      rstn = 1'b1;
      #1 c0 = prom_ack_cnt;
      wait_ack(1'b0, lat, d, a, rs);
      promreq = 1'b0;
      checks++; if (lat !== 3)                   begin errors++; $display("FAIL midrst_latency got=%0d exp=3", lat); end
      checks++; if (a !== 22'h000050)            begin errors++; $display("FAIL midrst_romaddr got=%h exp=000050", a); end
      checks++; if (d !== rom_byte(22'h000050))  begin errors++; $display("FAIL midrst_data got=%h exp=%h", d, rom_byte(22'h000050)); end
      idle(6);
      #1;
      checks++; if (prom_ack_cnt - c0 !== 1)     begin errors++; $display("FAIL midrst_ack_count got=%0d exp=1", prom_ack_cnt - c0); end
   endtask

`ifdef ROMSCHED_PREFETCH_EN
   task automatic test_prefetch;
      int lat; logic [7:0] d; logic [21:0] a; bit rs; int r0;
      promaddr = 21'h00100; promreq = 1'b1;
      wait_ack(1'b0, lat, d, a, rs);
      promreq = 1'b0;
      idle(8);
      #1 r0 = rom_req_cnt;
      promaddr = 21'h00101; promreq = 1'b1;
      wait_ack(1'b0, lat, d, a, rs);
      promreq = 1'b0;
      checks++; if (lat !== 1)                   begin errors++; $display("FAIL pf_hit_latency got=%0d exp=1", lat); end
      checks++; if (d !== rom_byte(22'h000111))  begin errors++; $display("FAIL pf_hit_data got=%h exp=%h", d, rom_byte(22'h000111)); end
      idle(4);
      #1;
      checks++; if (rom_req_cnt !== r0)          begin errors++; $display("FAIL pf_hit_romreq got=%0d exp=%0d", rom_req_cnt, r0); end
      promaddr = 21'h00200; promreq = 1'b1;
      wait_ack(1'b0, lat, d, a, rs);
      promreq = 1'b0;
      checks++; if (lat !== 3 || a !== 22'h000210) begin errors++; $display("FAIL pf_miss got=%0d/%h exp=3/000210", lat, a); end
      idle(8);
   endtask

   task automatic test_flush;
      int lat; logic [7:0] d; logic [21:0] a; bit rs;
      promaddr = 21'h00100; promreq = 1'b1;
      wait_ack(1'b0, lat, d, a, rs);
      promreq = 1'b0;
      idle(8);
      flush = 1'b1;
      idle(1);
      flush = 1'b0;
      promaddr = 21'h00101; promreq = 1'b1;
      wait_ack(1'b0, lat, d, a, rs);
      promreq = 1'b0;
      checks++; if (lat !== 3)                   begin errors++; $display("FAIL flush_latency got=%0d exp=3", lat); end
      checks++; if (a !== 22'h000111)            begin errors++; $display("FAIL flush_romaddr got=%h exp=000111", a); end
      checks++; if (d !== rom_byte(22'h000111))  begin errors++; $display("FAIL flush_data got=%h exp=%h", d, rom_byte(22'h000111)); end
      idle(8);
   endtask
`endif

   initial begin
      test_reset();
      test_prg_basic();
      idle(6);
      test_chr_basic();
      test_wrap();
      test_contention();
      test_back_to_back();
      test_reset_mid();
`ifdef ROMSCHED_PREFETCH_EN
      test_prefetch();
      test_flush();
`endif
      checks++; if (addr_unstable !== 1'b0) begin errors++; $display("FAIL romaddr_stable got=%b exp=0", addr_unstable); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
